uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Serial transmitter that consumes the one-cycle `flag` pulse of the upstream clock divider as its bit-period tick. It converts a parallel word into an asynchronous serial frame, LSB first: start bit, data, optional parity, then one stop bit. It uses a start/busy/done handshake with the upstream data source. Its output drives the board TX pin.

## Interface
- `NBITS_DATA`, default 8, number of data bits per frame (legal range 5–9).
- `NBITS_FOR_BITCNT`, default CeilLog2(`NBITS_DATA`), width of the internal data-bit counter.

- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset, sampled on rising `clk`.
- `baud_tick`  input  1  one-`clk` pulse per bit period; connected to the divider `flag`.
- `tx_start`  input  1  request to send `tx_data`; sampled only in IDLE.
- `tx_data`  input  `NBITS_DATA`  word to send; captured in the cycle `tx_start` is accepted.
- `tx_serial`  output  1  serial line; idles high.
- `busy`  output  1  high from the cycle after acceptance until the frame ends.
- `done`  output  1  one-cycle pulse at the end of the stop bit.

## Operation
- The block is a registered FSM with states IDLE, ALIGN, START, DATA, PARITY, STOP. There is a shift register of `NBITS_DATA` bits and a bit counter of `NBITS_FOR_BITCNT` bits.
- **IDLE**
  - `tx_serial`=1, `busy`=0.
  - When `tx_start`=1: latch `tx_data` and go to ALIGN.
  - A `baud_tick` in the same cycle as acceptance is not consumed.
- **ALIGN**
  - `tx_serial`=1, `busy`=1.
  - On `baud_tick`, go to START. This guarantees that every transmitted bit lasts exactly one full tick period.
- **START**
  - `tx_serial`=0.
  - On `baud_tick`: clear the bit counter and go to DATA.
- **DATA**
  - `tx_serial` = shift-register bit 0.
  - On `baud_tick`: shift right and increment the counter.
  - When the counter equals `NBITS_DATA`-1 and a tick occurs, go to PARITY (if compiled in) or STOP.
- **PARITY**
  - `tx_serial` = XOR of the latched word (even parity).
  - On `baud_tick`, go to STOP.
- **STOP**
  - `tx_serial`=1.
  - On `baud_tick`: `done`=1 for exactly the next cycle, `busy`=0, return to IDLE.
- A new `tx_start` can be accepted in the first IDLE cycle, which is the same cycle `done` is high. This gives back-to-back frames with no extra idle bit beyond the ALIGN wait.
- `tx_start` or `tx_data` changes while `busy`=1 are ignored; the latched word is not disturbed.
- `tx_serial`, `busy` and `done` are registered outputs, so they have no combinational path from the inputs.

## Timing
- **Reset values:** `tx_serial`=1, `busy`=0, `done`=0. The FSM is in IDLE, and the shift register and counter are 0.
- **Reset takes priority** over all inputs. Reset asserted mid-frame returns the block to IDLE at the next edge, with the line high and no `done` pulse.
- **Acceptance latency:** `busy` rises 1 cycle after the `tx_start` sample.
- **First start-bit edge:** `tx_serial` falls 1 cycle after the first `baud_tick` seen in ALIGN.
- **Bit period:** each bit is held from 1 cycle after tick N to 1 cycle after tick N+1.
- **Frame length:** 1 + `NBITS_DATA` + P + 1 tick periods after ALIGN, where P = 1 with parity and 0 without.
- **`done` timing:** asserted in the cycle after the STOP-ending tick. `busy` falls in that same cycle.
- **Tick and reset together:** a `baud_tick` during reset is ignored.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - **Defined:** the PARITY state is compiled in and an even-parity bit follows the data.
  - **Undefined:** PARITY logic is absent, DATA goes directly to STOP, and the frame is one tick period shorter.

## Test plan
- **Reset mid-frame:** assert `reset`=0 during DATA bit 3 → next cycle `tx_serial`=1, `busy`=0, `done`=0, no pulse; a subsequent `tx_start` sends a full frame.
- **Basic frame, no parity:** tick every 5 clocks, `tx_start` with `tx_data`=0xA5.
  - Line sequence per period: 1 (ALIGN), 0, 1,0,1,0,0,1,0,1, 1.
  - `done` pulses once; `busy` is high for the whole frame.
- **Parity build:** `UART_TX_PARITY_EN` defined.
  - 0xA5 → parity bit 0.
  - 0x07 → parity bit 1.
  - The frame is 11 periods after ALIGN.
- **Start ignored while busy:** pulse `tx_start` with 0xFF during the DATA bits of a 0x00 frame → line carries 0x00 only; exactly one `done`.
- **Back-to-back:** assert `tx_start` (0x3C) in the cycle `done` is high → second frame accepted with no lost word; `busy` drops for at most 1 cycle.
- **Tick coincident with start:** `tx_start` and `baud_tick` in the same IDLE cycle → remain in ALIGN until the next tick; the start bit lasts a full 5-clock period.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Asynchronous serial transmitter. It sends one frame per accepted word, LSB
// first: start bit (0), NBITS_DATA data bits, an optional even-parity bit, and
// one stop bit (1). The bit period comes from baud_tick, which is a one-cycle
// pulse from the upstream clock divider.
//
// Ports:
//   clk        in   system clock; all logic runs on the rising edge
//   reset      in   synchronous reset, active low
//   baud_tick  in   one-clk pulse per bit period
//   tx_start   in   send request; sampled only while idle
//   tx_data    in   word to send; captured when tx_start is accepted
//   tx_serial  out  serial line; idles high (registered)
//   busy       out  high while a frame is in progress (registered)
//   done       out  one-cycle pulse after the stop bit ends (registered)
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit follows the data bits.
//                      When undefined, DATA goes straight to STOP.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int NBITS_DATA       = 8,
    parameter int NBITS_FOR_BITCNT = $clog2(NBITS_DATA)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  tx_start,
    input  logic [NBITS_DATA-1:0] tx_data,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic [NBITS_FOR_BITCNT-1:0] LAST_BIT = NBITS_FOR_BITCNT'(NBITS_DATA - 1);

    state_t                      state_q, state_d;
    logic [NBITS_DATA-1:0]       shreg_q, shreg_d;
    logic [NBITS_FOR_BITCNT-1:0] bitcnt_q, bitcnt_d;
    logic                        tx_serial_d, busy_d, done_d;

`ifdef UART_TX_PARITY_EN
    // The shift register is consumed while the data bits go out, so the
    // parity of the latched word is computed once at acceptance and held.
    logic parity_q, parity_d;

    function automatic logic even_parity(input logic [NBITS_DATA-1:0] w);
        return ^w;
    endfunction
`endif

    // State and datapath registers; reset has priority over every input,
    // including a coincident baud_tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            tx_serial <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            tx_serial <= tx_serial_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                // A tick in the acceptance cycle is deliberately not used:
                // ALIGN waits for the next one so the start bit is a full period.
                if (tx_start) begin
                    shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(tx_data);
`endif
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (baud_tick) state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + NBITS_FOR_BITCNT'(1);
                    if (bitcnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each line
    // change lands one cycle after the tick that caused it.
    always_comb begin
        tx_serial_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
                done_d = (state_q == STOP);
            end
            START:  tx_serial_d = 1'b0;
            DATA:   tx_serial_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_serial_d = parity_d;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int NB  = 8;
    localparam int TPD = 5;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FB = NB + P + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          baud_tick;
    logic          tx_start;
    logic [NB-1:0] tx_data;
    logic          tx_serial, busy, done;

    uart_tx_serializer #(.NBITS_DATA(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int frames_ok = 0;
    int frames_aborted = 0;
    logic [NB-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected line level for frame bit b of word w (0=start, last=stop).
    function automatic logic exp_bit(input logic [NB-1:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= NB) return w[b-1];
        if (P == 1 && b == NB + 1) return ^w;
        return 1'b1;
    endfunction

    // Tick generator: one pulse every TPD clocks, updated just after the edge.
    int tcnt = 0;
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt == TPD - 1) ? 0 : tcnt + 1;
            baud_tick = (tcnt == TPD - 1);
        end
    end

    // Monitor: decodes each frame from the line and checks it against the
    // oldest queued word, cycle by cycle, including busy and the done pulse.
    initial begin
        bit            act  = 0;
        int            off  = 0;
        logic          prev = 1'b1;
        logic [NB-1:0] w    = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (act) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    frames_aborted++;
                end
                act  = 0;
                prev = 1'b1;
            end else begin
                if (!act && prev === 1'b1 && tx_serial === 1'b0) begin
                    act = 1;
                    off = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                        w = '0;
                    end else begin
                        w = exp_q.pop_front();
                    end
                end
                if (act) begin
                    if (off < TPD * FB) begin
                        chk($sformatf("line_w%0h_b%0d", w, off / TPD), tx_serial, exp_bit(w, off / TPD));
                        chk("busy_in_frame", busy, 1);
                        chk("done_in_frame", done, 0);
                        off++;
                    end else begin
                        chk("done_pulse", done, 1);
                        chk("busy_at_done", busy, 0);
                        chk("line_after_stop", tx_serial, 1);
                        frames_ok++;
                        act = 0;
                    end
                end else begin
                    chk("done_idle", done, 0);
                end
                prev = tx_serial;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [NB-1:0] w);
        tx_start = 1'b1;
        tx_data  = w;
        exp_q.push_back(w);
        cyc(1);
        tx_start = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget) begin
            cyc(1);
            if (done === 1'b1) break;
            n++;
        end
        if (n >= budget) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        tx_start = 1'b0;
        tx_data  = '0;
        cyc(3);
        chk("reset_tx_serial", tx_serial, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b1;
        cyc(2);

        // Basic frames.
        send(8'hA5);
        wait_done(200);
        cyc(3);
        send(8'h07);
        wait_done(200);
        cyc(3);

        // tx_start and new data while busy are ignored.
        send(8'h00);
        cyc(25);
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        cyc(1);
        tx_start = 1'b0;
        cyc(3);
        tx_data  = 8'h00;
        wait_done(200);
        cyc(20);
        chk("no_frame_after_ignored_start", busy, 0);

        // Back-to-back: next request in the done cycle.
        send(8'h5A);
        wait_done(200);
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        cyc(1);
        tx_start = 1'b0;
        chk("b2b_busy_back", busy, 1);
        wait_done(200);
        cyc(3);

        // Request coincident with a tick: the tick must not start the frame.
        n = 0;
        while (baud_tick !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("tick_found", baud_tick, 1);
        send(8'h96);
        cyc(2);
        chk("align_holds_line_high", tx_serial, 1);
        wait_done(200);
        cyc(3);

        // Reset during data bit 3.
        send(8'hF0);
        n = 0;
        while (tx_serial !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("frame_started", tx_serial, 0);
        cyc(TPD * 4 + 2);
        reset = 1'b0;
        cyc(1);
        chk("midreset_tx_serial", tx_serial, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        reset = 1'b1;
        cyc(TPD * 3);
        chk("no_done_after_reset", done, 0);
        send(8'hA5);
        wait_done(200);
        cyc(10);

        chk("queue_empty", exp_q.size(), 0);
        chk("frames_completed", frames_ok, 7);
        chk("frames_aborted", frames_aborted, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
